// File: rtl/pconv_pkg.sv
// Shared widths, saturation bounds and the product truncation helper for pconv_mac.
package pconv_pkg;

  localparam int W_W     = 8;
  localparam int D_W     = 16;
  localparam int D_SHIFT = 1;
  localparam int D_USE   = 15;
  localparam int P_KEEP  = 22;
  localparam int ACC_W   = 25;
  localparam int PROD_W  = W_W + D_USE + 1;

  localparam logic signed [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  // Keep the low P_KEEP product bits and sign-extend them from bit P_KEEP-1.
  function automatic logic signed [ACC_W-1:0] trunc_sext(input logic signed [PROD_W-1:0] prod);
    logic [P_KEEP-1:0] kept;
    kept = prod[P_KEEP-1:0];
    return {{(ACC_W-P_KEEP){kept[P_KEEP-1]}}, kept};
  endfunction

endpackage

// File: rtl/pconv_mac_if.sv
// Beat-in / result-out valid-ready bus of pconv_mac; slave is the MAC, master the driver.
interface pconv_mac_if
  import pconv_pkg::*;
#(
  parameter int TAPS = 3
);
  logic                  i_valid;
  logic                  i_ready;
  logic                  i_first;
  logic                  i_last;
  logic [TAPS*W_W-1:0]   i_weight;
  logic [TAPS*D_W-1:0]   i_data;
  logic                  o_valid;
  logic                  o_ready;
  logic [ACC_W-1:0]      o_data;
  logic                  o_sat;

  modport slave (
    input  i_valid, i_first, i_last, i_weight, i_data, o_ready,
    output i_ready, o_valid, o_data, o_sat
  );

  modport master (
    output i_valid, i_first, i_last, i_weight, i_data, o_ready,
    input  i_ready, o_valid, o_data, o_sat
  );
endinterface

// File: rtl/pconv_tap_mul.sv
// One MAC tap: extracts the unsigned data field, multiplies by the signed weight,
// and holds the product in the S1 register while the pipeline is stalled.
module pconv_tap_mul
  import pconv_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic [W_W-1:0]           weight,
  input  logic [D_W-1:0]           lane,
  output logic signed [PROD_W-1:0] prod_q
);

  logic [D_USE-1:0]          field_s;
  logic signed [PROD_W-1:0]  prod_d;
  logic                      unused_lsb_s;

  assign field_s      = lane[D_SHIFT +: D_USE];
  assign unused_lsb_s = ^lane[D_SHIFT-1:0];

  // Zero-extend the field so it multiplies as a non-negative signed operand.
  always_comb begin
    prod_d = prod_q;
    if (en) begin
      prod_d = $signed(weight) * $signed({1'b0, field_s});
    end else begin
      prod_d = prod_q;
    end
  end

  // S1 product register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q <= {PROD_W{1'b0}};
    end else begin
      prod_q <= prod_d;
    end
  end

endmodule

// File: rtl/pconv_mac.sv
// Two-stage partial-convolution MAC with first..last group accumulation.
// Define PCONV_SAT_EN to clamp the running sum and report o_sat instead of wrapping.
module pconv_mac
  import pconv_pkg::*;
#(
  parameter int TAPS = 3
)(
  input  logic        clk,
  input  logic        rst_n,
  pconv_mac_if.slave  bus
);

  logic                      adv_s;
  logic signed [PROD_W-1:0]  prod_s [TAPS];
  logic signed [ACC_W-1:0]   tsum_s;
  logic signed [ACC_W-1:0]   acc_in_s;
  logic signed [ACC_W:0]     wide_s;
  logic signed [ACC_W-1:0]   sum_s;
  logic                      sat_new_s;

  logic s1_valid_q, s1_valid_d;
  logic s1_first_q, s1_first_d;
  logic s1_last_q,  s1_last_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic sat_q, sat_d;
  logic o_valid_q, o_valid_d;
  logic [ACC_W-1:0] o_data_q, o_data_d;
  logic o_sat_q, o_sat_d;

  assign adv_s       = !o_valid_q | bus.o_ready;
  assign bus.i_ready = adv_s;
  assign bus.o_valid = o_valid_q;
  assign bus.o_data  = o_data_q;
  assign bus.o_sat   = o_sat_q;

  for (genvar t = 0; t < TAPS; t++) begin : g_tap
    pconv_tap_mul u_tap (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (adv_s),
      .weight (bus.i_weight[t*W_W +: W_W]),
      .lane   (bus.i_data[t*D_W +: D_W]),
      .prod_q (prod_s[t])
    );
  end

  // Tap adder tree and running sum; the first beat of a group ignores acc.
  always_comb begin
    tsum_s = {ACC_W{1'b0}};
    for (int t = 0; t < TAPS; t++) begin
      tsum_s = tsum_s + trunc_sext(prod_s[t]);
    end
    acc_in_s = s1_first_q ? {ACC_W{1'b0}} : $signed(acc_q);
    wide_s   = {tsum_s[ACC_W-1], tsum_s} + {acc_in_s[ACC_W-1], acc_in_s};
`ifdef PCONV_SAT_EN
    if (wide_s[ACC_W] != wide_s[ACC_W-1]) begin
      sum_s     = wide_s[ACC_W] ? SAT_MIN : SAT_MAX;
      sat_new_s = 1'b1;
    end else begin
      sum_s     = wide_s[ACC_W-1:0];
      sat_new_s = !s1_first_q & sat_q;
    end
`else
    sum_s     = wide_s[ACC_W-1:0];
    sat_new_s = 1'b0;
`endif
  end

  // Pipeline control: everything holds unless adv.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_first_d = s1_first_q;
    s1_last_d  = s1_last_q;
    acc_d      = acc_q;
    sat_d      = sat_q;
    o_valid_d  = o_valid_q;
    o_data_d   = o_data_q;
    o_sat_d    = o_sat_q;
    if (adv_s) begin
      s1_valid_d = bus.i_valid;
      s1_first_d = bus.i_first;
      s1_last_d  = bus.i_last;
      o_valid_d  = s1_valid_q & s1_last_q;
      if (s1_valid_q) begin
        acc_d = sum_s;
        sat_d = sat_new_s;
        if (s1_last_q) begin
          o_data_d = sum_s;
          o_sat_d  = sat_new_s;
        end else begin
          o_data_d = o_data_q;
          o_sat_d  = o_sat_q;
        end
      end else begin
        acc_d = acc_q;
        sat_d = sat_q;
      end
    end else begin
      o_valid_d = o_valid_q;
    end
  end

  // S1 control bits, accumulator and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_first_q <= 1'b0;
      s1_last_q  <= 1'b0;
      acc_q      <= {ACC_W{1'b0}};
      sat_q      <= 1'b0;
      o_valid_q  <= 1'b0;
      o_data_q   <= {ACC_W{1'b0}};
      o_sat_q    <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_first_q <= s1_first_d;
      s1_last_q  <= s1_last_d;
      acc_q      <= acc_d;
      sat_q      <= sat_d;
      o_valid_q  <= o_valid_d;
      o_data_q   <= o_data_d;
      o_sat_q    <= o_sat_d;
    end
  end

endmodule

// File: tb/tb_pconv_mac.sv
// Scoreboard bench for pconv_mac: directed beats push expected results, a monitor pops on each transfer.
module tb_pconv_mac;
  import pconv_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  logic [ACC_W:0] exp_q [$];

  pconv_mac_if #(.TAPS(3)) bus ();

  pconv_mac #(.TAPS(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [23:0] wv(input int w2, input int w1, input int w0);
    return {w2[7:0], w1[7:0], w0[7:0]};
  endfunction

  function automatic logic [47:0] ld(input int f2, input int f1, input int f0);
    return {f2[14:0], 1'b0, f1[14:0], 1'b0, f0[14:0], 1'b0};
  endfunction

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Present one beat from a negedge; returns after the accepting posedge, valid left high.
  task automatic send(input logic [23:0] w, input logic [47:0] d, input logic f, input logic l,
                      input int exp_data, input logic exp_sat);
    int n;
    bus.i_valid  = 1'b1;
    bus.i_weight = w;
    bus.i_data   = d;
    bus.i_first  = f;
    bus.i_last   = l;
    n = 0;
    while (!bus.i_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.i_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: i_ready stuck at 0");
    end else begin
      if (l) exp_q.push_back({exp_sat, exp_data[ACC_W-1:0]});
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic idle(input int n);
    bus.i_valid = 1'b0;
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.o_valid) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain_queue_empty", exp_q.size(), 0);
  endtask

  // Monitor: compare every completed output transfer against the scoreboard head.
  always @(negedge clk) begin
    logic [ACC_W:0] e;
    if (rst_n && bus.o_valid && bus.o_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got o_data=%0d expected none", $signed(bus.o_data));
      end else begin
        e = exp_q.pop_front();
        checks += 2;
        if (bus.o_data !== e[ACC_W-1:0]) begin
          errors++;
          $display("FAIL o_data: got %0d expected %0d", $signed(bus.o_data), $signed(e[ACC_W-1:0]));
        end
        if (bus.o_sat !== e[ACC_W]) begin
          errors++;
          $display("FAIL o_sat: got %0b expected %0b", bus.o_sat, e[ACC_W]);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] w_a;
    logic [47:0] d_a;
    int          n;
    logic        sat_exp;
    int          sat_data;
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    bus.i_valid  = 1'b0;
    bus.i_first  = 1'b0;
    bus.i_last   = 1'b0;
    bus.i_weight = 24'h000000;
    bus.i_data   = 48'h000000000000;
    bus.o_ready  = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_i_ready", int'(bus.i_ready), 1);
    check("reset_o_valid", int'(bus.o_valid), 0);
    check("reset_o_data", int'(bus.o_data), 0);
    check("reset_o_sat", int'(bus.o_sat), 0);
    rst_n = 1'b1;
    @(negedge clk);

    w_a = wv(-1, 2, 1);
    d_a = ld(3, 2, 1);
    send(w_a, d_a, 1'b1, 1'b1, 2, 1'b0);
    idle(3);

    send(w_a, d_a, 1'b1, 1'b0, 0, 1'b0);
    send(w_a, d_a, 1'b0, 1'b0, 0, 1'b0);
    send(w_a, d_a, 1'b0, 1'b1, 6, 1'b0);
    idle(3);

    send(wv(0, 0, -128), ld(0, 0, 32'h7FFF), 1'b1, 1'b1, 128, 1'b0);
    send(wv(0, 0, 1), ld(0, 0, 2), 1'b1, 1'b1, 2, 1'b0);
    send(wv(0, 0, 1), ld(0, 0, 2), 1'b0, 1'b1, 4, 1'b0);
    idle(1);
    send(wv(0, 0, 3), ld(0, 0, 4), 1'b1, 1'b0, 0, 1'b0);
    idle(3);
    send(wv(0, 0, 3), ld(0, 0, 4), 1'b0, 1'b1, 24, 1'b0);
    idle(1);
    drain();

    bus.o_ready = 1'b0;
    fork
      begin
        send(wv(0, 0, 1), ld(0, 0, 5), 1'b1, 1'b1, 5, 1'b0);
        send(wv(0, 0, 1), ld(0, 0, 7), 1'b1, 1'b1, 7, 1'b0);
        send(wv(0, 0, 1), ld(0, 0, 9), 1'b1, 1'b1, 9, 1'b0);
        idle(1);
      end
      begin
        n = 0;
        while (!bus.o_valid && n < 20) begin
          @(negedge clk);
          n++;
        end
        for (int i = 0; i < 5; i++) begin
          check("stall_i_ready", int'(bus.i_ready), 0);
          check("stall_o_data", int'($signed(bus.o_data)), 5);
          @(negedge clk);
        end
        @(posedge clk);
        #2 bus.o_ready = 1'b1;
      end
    join
    drain();

`ifdef PCONV_SAT_EN
    sat_data = 16777215;
    sat_exp  = 1'b1;
`else
    sat_data = -14680073;
    sat_exp  = 1'b0;
`endif
    send(wv(127, 127, 127), 48'h810281028102, 1'b1, 1'b0, 0, 1'b0);
    send(wv(127, 127, 127), 48'h810281028102, 1'b0, 1'b0, 0, 1'b0);
    send(wv(127, 127, 127), 48'h810281028102, 1'b0, 1'b1, sat_data, sat_exp);
    idle(1);
    drain();

    send(wv(0, 0, 10), ld(0, 0, 10), 1'b1, 1'b0, 0, 1'b0);
    send(wv(0, 0, 10), ld(0, 0, 10), 1'b0, 1'b0, 0, 1'b0);
    bus.i_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midreset_o_valid", int'(bus.o_valid), 0);
    @(negedge clk);
    send(wv(0, 0, 2), ld(0, 0, 3), 1'b1, 1'b1, 6, 1'b0);
    idle(4);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
